// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multicycle MIPS-lite control sequencer:
// ALU class codes, opcodes, state encodings and the decoded opcode class.
package mc_sequencer_pkg;

   localparam int ALU_OP_LENGTH  = 3;
   localparam int DM_TIMEOUT_DEF = 15;

   localparam logic [ALU_OP_LENGTH-1:0] ALU_ADD  = 3'd0;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_SUB  = 3'd1;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_FUNC = 3'd2;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_OR   = 3'd3;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_LUI  = 3'd4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] PC_SRC_SEQ = 2'd0;
   localparam logic [1:0] PC_SRC_BR  = 2'd1;
   localparam logic [1:0] PC_SRC_J   = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_BRANCH = 3'd5,
      S_JUMP   = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   typedef struct packed {
      logic rtype;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic illegal;
   } op_class_t;

endpackage

// File: rtl/mc_sequencer_if.sv
// Control bus between the sequencer and the datapath: IR opcode / flags in,
// write enables, mux selects and status out.
interface mc_sequencer_if;
   import mc_sequencer_pkg::*;

   logic [5:0]               op;
   logic                     zero;
   logic                     dm_ready;
   logic                     ir_we;
   logic                     pc_we;
   logic [1:0]               pc_src;
   logic                     reg_we;
   logic                     reg_dst;
   logic                     wb_sel;
   logic                     alu_src;
   logic                     ext_op;
   logic [ALU_OP_LENGTH-1:0] alu_op;
   logic                     dm_req;
   logic                     dm_we;
   logic                     illegal;
   logic                     bus_err;
   logic [2:0]               state_o;
   logic [31:0]              instret;

   modport master (
      input  op, zero, dm_ready,
      output ir_we, pc_we, pc_src, reg_we, reg_dst, wb_sel, alu_src, ext_op,
             alu_op, dm_req, dm_we, illegal, bus_err, state_o, instret
   );

   modport slave (
      output op, zero, dm_ready,
      input  ir_we, pc_we, pc_src, reg_we, reg_dst, wb_sel, alu_src, ext_op,
             alu_op, dm_req, dm_we, illegal, bus_err, state_o, instret
   );
endinterface

// File: rtl/mc_sequencer_op_decode.sv
// Opcode to one-hot instruction class, plus immediate extension mode.
module mc_op_decode
   import mc_sequencer_pkg::*;
(
   input  logic [5:0] i_op,
   output op_class_t  o_cls,
   output logic       o_ext_op
);

   always_comb begin
      o_cls    = '0;
      o_ext_op = 1'b0;
      case (i_op)
         OP_RTYPE: o_cls.rtype = 1'b1;
         OP_ORI:   o_cls.ori   = 1'b1;
         OP_LUI:   o_cls.lui   = 1'b1;
         OP_LW:    begin o_cls.lw  = 1'b1; o_ext_op = 1'b1; end
         OP_SW:    begin o_cls.sw  = 1'b1; o_ext_op = 1'b1; end
         OP_BEQ:   begin o_cls.beq = 1'b1; o_ext_op = 1'b1; end
         OP_J:     o_cls.j     = 1'b1;
         default:  o_cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control FSM: one state sequence per instruction, a single pc_we
// in its last state, a bounded data-memory wait and a retired-instruction count.
module mc_sequencer
   import mc_sequencer_pkg::*;
#(
   parameter int DM_TIMEOUT = DM_TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   mc_sequencer_if.master bus
);

   localparam int WCW = $clog2(DM_TIMEOUT + 1);
   localparam logic [WCW-1:0] WC_LAST = WCW'(DM_TIMEOUT - 1);

   state_t                   r_state;
   state_t                   w_next;
   logic [WCW-1:0]           r_wait_cnt;
   logic [31:0]              r_instret;
   op_class_t                w_cls;
   logic                     w_ext_op;

   logic                     w_ir_we, w_pc_we, w_reg_we, w_reg_dst, w_wb_sel;
   logic                     w_alu_src, w_dm_req, w_dm_we, w_illegal, w_bus_err;
   logic [1:0]               w_pc_src;
   logic [ALU_OP_LENGTH-1:0] w_alu_op;

   mc_op_decode u_dec (
      .i_op     (bus.op),
      .o_cls    (w_cls),
      .o_ext_op (w_ext_op)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (w_cls.rtype | w_cls.ori | w_cls.lui | w_cls.lw | w_cls.sw) w_next = S_EXEC;
            else if (w_cls.beq) w_next = S_BRANCH;
            else if (w_cls.j)   w_next = S_JUMP;
            else                w_next = S_TRAP;
         end
         S_EXEC:   w_next = (w_cls.lw | w_cls.sw) ? S_MEM : S_WB;
         // dm_ready in the final allowed cycle takes priority over the timeout
         S_MEM: begin
            if (bus.dm_ready)            w_next = w_cls.lw ? S_WB : S_FETCH;
            else if (r_wait_cnt == WC_LAST) w_next = S_TRAP;
            else                         w_next = S_MEM;
         end
         default:  w_next = S_FETCH;
      endcase
   end

   // Outputs are forced idle while rst is high so nothing glitches during reset.
   always_comb begin
      w_ir_we   = 1'b0;
      w_pc_we   = 1'b0;
      w_pc_src  = PC_SRC_SEQ;
      w_reg_we  = 1'b0;
      w_reg_dst = 1'b0;
      w_wb_sel  = 1'b0;
      w_alu_src = 1'b0;
      w_alu_op  = ALU_ADD;
      w_dm_req  = 1'b0;
      w_dm_we   = 1'b0;
      w_illegal = 1'b0;
      w_bus_err = 1'b0;
      if (!rst) begin
         case (r_state)
            S_FETCH: w_ir_we = 1'b1;
            S_EXEC: begin
               w_alu_src = ~w_cls.rtype;
               if (w_cls.rtype)    w_alu_op = ALU_FUNC;
               else if (w_cls.ori) w_alu_op = ALU_OR;
               else if (w_cls.lui) w_alu_op = ALU_LUI;
            end
            S_MEM: begin
               w_dm_req = 1'b1;
               w_dm_we  = w_cls.sw;
               w_pc_we  = w_cls.sw & bus.dm_ready;
            end
            S_WB: begin
               w_reg_we  = 1'b1;
               w_pc_we   = 1'b1;
               w_reg_dst = w_cls.rtype;
               w_wb_sel  = w_cls.lw;
            end
            S_BRANCH: begin
               w_alu_op = ALU_SUB;
               w_pc_we  = 1'b1;
               w_pc_src = bus.zero ? PC_SRC_BR : PC_SRC_SEQ;
            end
            S_JUMP: begin
               w_pc_we  = 1'b1;
               w_pc_src = PC_SRC_J;
            end
            // only an unsupported opcode reaches TRAP via DECODE; lw/sw arrive from MEM
            S_TRAP: begin
               w_pc_we   = 1'b1;
               w_illegal = w_cls.illegal;
               w_bus_err = ~w_cls.illegal;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_wait_cnt <= '0;
      else if (r_state != S_MEM) r_wait_cnt <= '0;
      else                      r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_instret <= '0;
      else if (w_pc_we) r_instret <= r_instret + 32'd1;
   end

   assign bus.ir_we   = w_ir_we;
   assign bus.pc_we   = w_pc_we;
   assign bus.pc_src  = w_pc_src;
   assign bus.reg_we  = w_reg_we;
   assign bus.reg_dst = w_reg_dst;
   assign bus.wb_sel  = w_wb_sel;
   assign bus.alu_src = w_alu_src;
   assign bus.ext_op  = w_ext_op;
   assign bus.alu_op  = w_alu_op;
   assign bus.dm_req  = w_dm_req;
   assign bus.dm_we   = w_dm_we;
   assign bus.illegal = w_illegal;
   assign bus.bus_err = w_bus_err;
   assign bus.state_o = r_state;
   assign bus.instret = r_instret;

endmodule
